pipecleaner_pattern_engine: RTL and testbench



---
 rtl/pipecleaner_pkg.sv | 59 +++++
 rtl/pipecleaner_pattern_gen.sv | 83 ++++++++
 rtl/pipecleaner_pattern_engine.sv | 212 +++++++++++++++++++++
 tb/tb_pipecleaner_pattern_engine.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipecleaner_pkg.sv
// pipecleaner_pkg: shared types and constants for the pipecleaner BIST engine.
// Holds the pattern-mode and FSM-state enums, the Fibonacci LFSR tap masks
// (indexed by word width) and the CHECKER base-pattern helper.
// Helper functions support word widths up to MAX_WIDTH bits.
package pipecleaner_pkg;

  typedef enum logic [1:0] {
    MODE_COUNT   = 2'd0,
    MODE_WALK1   = 2'd1,
    MODE_PRBS    = 2'd2,
    MODE_CHECKER = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    STATE_IDLE  = 2'd0,
    STATE_RUN   = 2'd1,
    STATE_DRAIN = 2'd2,
    STATE_DONE  = 2'd3
  } state_e;

  localparam int MAX_WIDTH = 64;

  // Tap masks for a left-shifting Fibonacci LFSR: bit k set means the
  // register bit k feeds the XOR that becomes the new bit 0.
  //   8 : x^8  + x^6  + x^5 + x^4 + 1
  //   16: x^16 + x^15 + x^13 + x^4 + 1
  //   32: x^32 + x^22 + x^2 + x^1 + 1
  // Other widths fall back to the two top bits; the top bit is always a tap,
  // so the shift stays invertible and a non-zero seed never reaches zero.
  function automatic logic [MAX_WIDTH-1:0] lfsr_taps(input int w);
    logic [MAX_WIDTH-1:0] m;
    m = '0;
    case (w)
      8:       m[7:0]  = 8'hB8;
      16:      m[15:0] = 16'hD008;
      32:      m[31:0] = 32'h8020_0003;
      default: begin
        m[w-1] = 1'b1;
        m[w-2] = 1'b1;
      end
    endcase
    return m;
  endfunction

  // CHECKER base word {w/2{2'b01}}: every even bit set, every odd bit clear.
  function automatic logic [MAX_WIDTH-1:0] checker_base(input int w);
    logic [MAX_WIDTH-1:0] p;
    p = '0;
    for (int i = 0; i < MAX_WIDTH; i++) begin
      if ((i < w) && ((i % 2) == 0)) begin
        p[i] = 1'b1;
      end else begin
        p[i] = 1'b0;
      end
    end
    return p;
  endfunction

endpackage

// File: rtl/pipecleaner_pattern_gen.sv
// pipecleaner_pattern_gen: one per-channel pattern generator.
// i_load latches the mode and the channel's word 0; i_step advances to the
// next word. o_word is the current word, o_word_next is what the register
// takes at the next edge (seed on load, successor on step, hold otherwise),
// so the parent can register the outgoing data in lock-step.
module pipecleaner_pattern_gen
  import pipecleaner_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      i_chan,
  input  mode_e            i_mode,
  input  logic             i_load,
  input  logic             i_step,
  output logic [WIDTH-1:0] o_word,
  output logic [WIDTH-1:0] o_word_next
);

  localparam logic [WIDTH-1:0] TAPS = WIDTH'(lfsr_taps(WIDTH));
  localparam logic [WIDTH-1:0] CHK  = WIDTH'(checker_base(WIDTH));
  localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

  mode_e            r_mode;
  logic [WIDTH-1:0] r_word;
  logic [WIDTH-1:0] w_seed;
  logic [WIDTH-1:0] w_adv;
  logic [WIDTH-1:0] w_next;

  // Word 0 for this channel in the requested mode
  always_comb begin
    w_seed = '0;
    case (i_mode)
      MODE_COUNT:   w_seed = WIDTH'(i_chan);
      MODE_WALK1:   w_seed = ONE << (i_chan % 32'(WIDTH));
      MODE_PRBS:    w_seed = WIDTH'(i_chan + 32'd1);
      MODE_CHECKER: w_seed = i_chan[0] ? ~CHK : CHK;
      default:      w_seed = '0;
    endcase
  end

  // Successor of the current word in the latched mode
  always_comb begin
    w_adv = r_word;
    case (r_mode)
      MODE_COUNT:   w_adv = r_word + ONE;
      MODE_WALK1:   w_adv = {r_word[WIDTH-2:0], r_word[WIDTH-1]};
      MODE_PRBS:    w_adv = {r_word[WIDTH-2:0], ^(r_word & TAPS)};
      MODE_CHECKER: w_adv = ~r_word;
      default:      w_adv = r_word;
    endcase
  end

  // Select seed, successor or hold
  always_comb begin
    w_next = r_word;
    if (i_load) begin
      w_next = w_seed;
    end else if (i_step) begin
      w_next = w_adv;
    end else begin
      w_next = r_word;
    end
  end

  // Pattern and mode registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_word <= '0;
      r_mode <= MODE_COUNT;
    end else begin
      r_word <= w_next;
      if (i_load) begin
        r_mode <= i_mode;
      end
    end
  end

  assign o_word      = r_word;
  assign o_word_next = w_next;

endmodule

// File: rtl/pipecleaner_pattern_engine.sv
// pipecleaner_pattern_engine: N-channel BIST pattern generator and loopback
// checker. Holds the IDLE/RUN/DRAIN/DONE FSM, the burst/drain counter, the
// valid-tagged expected-data delay line, the comparator and the saturating
// error counter. Optional feature macro: PIPECLEANER_ERR_INJECT_EN enables
// single-word error injection on channel 0 bit 0 via `inject`.
module pipecleaner_pattern_engine
  import pipecleaner_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 2,
  parameter int LOOP_LAT = 2,
  parameter int LEN_W    = 8,
  parameter int ERR_W    = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      ena,
  input  logic [1:0]                mode,
  input  logic [LEN_W-1:0]          burst_len,
  input  logic                      start,
  input  logic                      abort,
  input  logic                      inject,
  input  logic [CHANNELS*WIDTH-1:0] rx_data,
  output logic [CHANNELS*WIDTH-1:0] tx_data,
  output logic                      tx_valid,
  output logic                      busy,
  output logic                      done,
  output logic                      pass,
  output logic [ERR_W-1:0]          err_count
);

  localparam int DW    = CHANNELS * WIDTH;
  localparam int LAT_W = $clog2(LOOP_LAT + 1);
  localparam int CNT_W = (LEN_W > LAT_W) ? LEN_W : LAT_W;

  localparam logic [1:0] ST_IDLE  = 2'b00;
  localparam logic [1:0] ST_RUN   = 2'b01;
  localparam logic [1:0] ST_DRAIN = 2'b10;
  localparam logic [1:0] ST_DONE  = 2'b11;

  localparam logic [CNT_W-1:0] LAT_M1 = CNT_W'(LOOP_LAT - 1);

  logic [1:0]       r_state;
  logic [1:0]       w_state_next;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_next;
  logic [CNT_W-1:0] w_len_m1;
  logic             w_load;
  logic             w_step;

  logic [DW-1:0]    w_gen_word;
  logic [DW-1:0]    w_gen_next;
  logic [DW-1:0]    w_inj_mask;
  logic [DW-1:0]    w_tx_next;
  logic [DW-1:0]    r_tx_data;
  logic             r_tx_valid;
  logic             r_busy;
  logic             r_done;
  logic             r_pass;

  logic [DW:0]      r_dline [LOOP_LAT];
  logic [DW:0]      w_dline_in;
  logic             w_mismatch;
  logic [ERR_W-1:0] r_err;
  logic [ERR_W-1:0] w_err_next;

  // Remaining words after word 0; a zero burst length behaves as one word
  assign w_len_m1 = (burst_len == '0) ? '0 : CNT_W'(burst_len - LEN_W'(1));

  // Next state, counter reload and generator load/step strobes; abort dominates
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_load       = 1'b0;
    w_step       = 1'b0;
    case (r_state)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          w_state_next = ST_RUN;
          w_cnt_next   = w_len_m1;
          w_load       = 1'b1;
        end else begin
          w_state_next = r_state;
        end
      end
      ST_RUN: begin
        if (r_cnt == '0) begin
          w_state_next = ST_DRAIN;
          w_cnt_next   = LAT_M1;
        end else begin
          w_step     = 1'b1;
          w_cnt_next = r_cnt - CNT_W'(1);
        end
      end
      ST_DRAIN: begin
        if (r_cnt == '0) begin
          w_state_next = ST_DONE;
        end else begin
          w_cnt_next = r_cnt - CNT_W'(1);
        end
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
    if (abort) begin
      w_state_next = ST_IDLE;
      w_cnt_next   = '0;
      w_load       = 1'b0;
      w_step       = 1'b0;
    end else begin
      w_state_next = w_state_next;
    end
  end

  genvar c;
  generate
    for (c = 0; c < CHANNELS; c++) begin : g_chan
      pipecleaner_pattern_gen #(
        .WIDTH (WIDTH)
      ) u_gen (
        .clk         (clk),
        .rst         (rst),
        .i_chan      (32'(c)),
        .i_mode      (mode_e'(mode)),
        .i_load      (w_load & ena),
        .i_step      (w_step & ena),
        .o_word      (w_gen_word[c*WIDTH +: WIDTH]),
        .o_word_next (w_gen_next[c*WIDTH +: WIDTH])
      );
    end
  endgenerate

`ifdef PIPECLEANER_ERR_INJECT_EN
  // Only a word that follows within the same burst can carry the flip
  assign w_inj_mask = (inject && w_step) ? DW'(1) : '0;
`else
  logic w_unused_inject;
  assign w_unused_inject = inject;
  assign w_inj_mask      = '0;
`endif

  assign w_tx_next = (w_load || w_step) ? (w_gen_next ^ w_inj_mask) : '0;

  // Expected copy is the clean generator word, zeroed and untagged when idle
  assign w_dline_in = r_tx_valid ? {1'b1, w_gen_word} : '0;
  assign w_mismatch = r_dline[LOOP_LAT-1][DW] &&
                      (rx_data != r_dline[LOOP_LAT-1][DW-1:0]);

  // Error counter: clear on burst start, saturating +1 per mismatching cycle
  always_comb begin
    w_err_next = r_err;
    if (w_load) begin
      w_err_next = '0;
    end else if (w_mismatch && (r_err != '1)) begin
      w_err_next = r_err + ERR_W'(1);
    end else begin
      w_err_next = r_err;
    end
  end

  // FSM, counters and registered outputs advance together while enabled
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_cnt      <= '0;
      r_tx_data  <= '0;
      r_tx_valid <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_pass     <= 1'b0;
      r_err      <= '0;
    end else if (ena) begin
      r_state    <= w_state_next;
      r_cnt      <= w_cnt_next;
      r_tx_data  <= w_tx_next;
      r_tx_valid <= w_load || w_step;
      r_busy     <= (w_state_next == ST_RUN) || (w_state_next == ST_DRAIN);
      r_done     <= (w_state_next == ST_DONE);
      r_pass     <= (w_state_next == ST_DONE) && (w_err_next == '0);
      r_err      <= w_err_next;
    end
  end

  // Valid-tagged delay line; flushed on burst start and abort so stale words never compare
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < LOOP_LAT; i++) begin
        r_dline[i] <= '0;
      end
    end else if (ena) begin
      if (w_load || abort) begin
        for (int i = 0; i < LOOP_LAT; i++) begin
          r_dline[i] <= '0;
        end
      end else begin
        r_dline[0] <= w_dline_in;
        for (int i = 1; i < LOOP_LAT; i++) begin
          r_dline[i] <= r_dline[i-1];
        end
      end
    end
  end

  assign tx_data   = r_tx_data;
  assign tx_valid  = r_tx_valid;
  assign busy      = r_busy;
  assign done      = r_done;
  assign pass      = r_pass;
  assign err_count = r_err;

endmodule

// File: tb/tb_pipecleaner_pattern_engine.sv
// Self-checking bench for pipecleaner_pattern_engine (WIDTH=8, CHANNELS=2,
// LOOP_LAT=2) with a 2-cycle loopback model from tx_data to rx_data.
module tb_pipecleaner_pattern_engine;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ena = 1'b1;
  logic [1:0]  mode = 2'd0;
  logic [7:0]  burst_len = 8'd0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic        inject = 1'b0;
  logic [15:0] rx_data;
  logic [15:0] tx_data;
  logic        tx_valid;
  logic        busy;
  logic        done;
  logic        pass;
  logic [15:0] err_count;

  logic [15:0] lb1 = 16'h0000;
  logic [15:0] lb2 = 16'h0000;
  bit          force_now = 1'b0;
  bit          force_word [256];

  int total = 0;
  int bad   = 0;

  logic [15:0] cap_q [$];
  int          cap_cycles;
  bit          cap_timeout;
  logic        cap_pass;
  logic [15:0] cap_err;
  int          hold_bad;
  logic [15:0] hold_val;

  pipecleaner_pattern_engine #(
    .WIDTH(8), .CHANNELS(2), .LOOP_LAT(2), .LEN_W(8), .ERR_W(16)
  ) dut (
    .clk(clk), .rst(rst), .ena(ena), .mode(mode), .burst_len(burst_len),
    .start(start), .abort(abort), .inject(inject), .rx_data(rx_data),
    .tx_data(tx_data), .tx_valid(tx_valid), .busy(busy), .done(done),
    .pass(pass), .err_count(err_count)
  );

  always #5 clk = ~clk;

  // Loopback wire: two register stages, frozen with the engine, optional bit-3 corruption on channel 0
  always @(posedge clk) begin
    if (ena) begin
      lb1 <= tx_data | (force_now ? 16'h0008 : 16'h0000);
      lb2 <= lb1;
    end
  end
  assign rx_data = lb2;

  // Reference pattern: word n of channel c in mode m, straight from the pattern rules
  function automatic logic [7:0] model_word(input int m, input int c, input int n);
    logic [7:0] s;
    case (m)
      0: return 8'((c + n) % 256);
      1: return 8'(1 << ((n + c) % 8));
      2: begin
        s = 8'(c + 1);
        for (int k = 0; k < n; k++) s = {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
        return s;
      end
      default: return (((n + c) % 2) == 0) ? 8'h55 : 8'hAA;
    endcase
  endfunction

  function automatic logic [15:0] model_pair(input int m, input int n);
    return {model_word(m, 1, n), model_word(m, 0, n)};
  endfunction

  task automatic clear_force();
    for (int i = 0; i < 256; i++) force_word[i] = 1'b0;
  endtask

  // Runs one burst from IDLE/DONE and records the words, done timing and result
  task automatic run_burst(input int m, input int len_in, input int inj_cyc,
                           input int restart_cyc, input int gap_cyc, input int gap_len);
    int cyc;
    bit prev_ena;
    int idx;
    cap_q.delete();
    hold_bad = 0;
    mode = 2'(m); burst_len = 8'(len_in); start = 1'b1; ena = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    mode = 2'($urandom_range(0, 3));
    burst_len = 8'($urandom_range(0, 255));
    prev_ena = 1'b1;
    cyc = 1;
    hold_val = tx_data;
    while (done !== 1'b1 && cyc < 3000) begin
      if (prev_ena) begin
        if (tx_valid === 1'b1) cap_q.push_back(tx_data);
      end else if (tx_data !== hold_val) begin
        hold_bad++;
      end
      hold_val = tx_data;
      idx = int'(cap_q.size()) - 1;
      force_now = (tx_valid === 1'b1) && (idx >= 0) && force_word[idx];
      inject = (cyc == inj_cyc);
      start  = (cyc == restart_cyc);
      ena    = !((gap_len > 0) && (cyc >= gap_cyc) && (cyc < gap_cyc + gap_len));
      prev_ena = ena;
      @(posedge clk); #1;
      cyc++;
    end
    inject = 1'b0; start = 1'b0; ena = 1'b1; force_now = 1'b0;
    cap_cycles  = cyc;
    cap_timeout = (cyc >= 3000);
    cap_pass    = pass;
    cap_err     = err_count;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    total++; if (tx_data !== 16'h0000) begin bad++; $display("FAIL reset_tx_data got=%h want=0000", tx_data); end
    total++; if (tx_valid !== 1'b0) begin bad++; $display("FAIL reset_tx_valid got=%b want=0", tx_valid); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", done); end
    total++; if (pass !== 1'b0) begin bad++; $display("FAIL reset_pass got=%b want=0", pass); end
    total++; if (err_count !== 16'd0) begin bad++; $display("FAIL reset_err got=%0d want=0", err_count); end
  endtask

  task automatic test_count();
    clear_force();
    run_burst(0, 4, 0, 0, 0, 0);
    total++; if (cap_timeout) begin bad++; $display("FAIL count_timeout got=timeout want=done"); end
    total++; if (cap_q.size() != 4) begin bad++; $display("FAIL count_len got=%0d want=4", cap_q.size()); end
    for (int n = 0; n < 4 && n < cap_q.size(); n++) begin
      total++; if (cap_q[n] !== model_pair(0, n)) begin bad++; $display("FAIL count_word%0d got=%h want=%h", n, cap_q[n], model_pair(0, n)); end
    end
    total++; if (cap_cycles != 7) begin bad++; $display("FAIL count_done_cycle got=%0d want=7", cap_cycles); end
    total++; if (cap_pass !== 1'b1) begin bad++; $display("FAIL count_pass got=%b want=1", cap_pass); end
    total++; if (cap_err !== 16'd0) begin bad++; $display("FAIL count_err got=%0d want=0", cap_err); end
  endtask

  task automatic test_prbs();
    int zeros;
    int wrong;
    clear_force();
    run_burst(2, 255, 0, 0, 0, 0);
    zeros = 0; wrong = 0;
    total++; if (cap_q.size() != 255) begin bad++; $display("FAIL prbs_len got=%0d want=255", cap_q.size()); end
    for (int n = 0; n < cap_q.size(); n++) begin
      if (cap_q[n][7:0] == 8'h00 || cap_q[n][15:8] == 8'h00) zeros++;
      if (cap_q[n] !== model_pair(2, n)) wrong++;
    end
    total++; if (cap_q.size() > 1 && cap_q[0][7:0] !== 8'h01) begin bad++; $display("FAIL prbs_first got=%h want=01", cap_q[0][7:0]); end
    total++; if (cap_q.size() > 1 && cap_q[1][7:0] !== 8'h02) begin bad++; $display("FAIL prbs_second got=%h want=02", cap_q[1][7:0]); end
    total++; if (wrong != 0) begin bad++; $display("FAIL prbs_words got=%0d_wrong want=0_wrong", wrong); end
    total++; if (zeros != 0) begin bad++; $display("FAIL prbs_nonzero got=%0d_zero want=0_zero", zeros); end
    total++; if (cap_cycles != 258) begin bad++; $display("FAIL prbs_done_cycle got=%0d want=258", cap_cycles); end
    total++; if (cap_pass !== 1'b1) begin bad++; $display("FAIL prbs_pass got=%b want=1", cap_pass); end
  endtask

  task automatic test_checker();
    clear_force();
    force_word[2] = 1'b1;
    force_word[4] = 1'b1;
    run_burst(3, 6, 0, 0, 0, 0);
    clear_force();
    total++; if (cap_q.size() != 6) begin bad++; $display("FAIL checker_len got=%0d want=6", cap_q.size()); end
    for (int n = 0; n < 6 && n < cap_q.size(); n++) begin
      total++; if (cap_q[n] !== model_pair(3, n)) begin bad++; $display("FAIL checker_word%0d got=%h want=%h", n, cap_q[n], model_pair(3, n)); end
    end
    total++; if (cap_err !== 16'd2) begin bad++; $display("FAIL checker_err got=%0d want=2", cap_err); end
    total++; if (cap_pass !== 1'b0) begin bad++; $display("FAIL checker_pass got=%b want=0", cap_pass); end
  endtask

  task automatic test_abort_walk();
    mode = 2'd0; burst_len = 8'd20; start = 1'b1; abort = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; abort = 1'b0;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL abort_wins_busy got=%b want=0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL abort_wins_done got=%b want=0", done); end
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1 abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL abort_busy got=%b want=0", busy); end
    total++; if (tx_valid !== 1'b0) begin bad++; $display("FAIL abort_tx_valid got=%b want=0", tx_valid); end
    total++; if (tx_data !== 16'h0000) begin bad++; $display("FAIL abort_tx_data got=%h want=0000", tx_data); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL abort_done got=%b want=0", done); end
    repeat (3) @(posedge clk);
    #1;
    clear_force();
    run_burst(1, 8, 0, 0, 0, 0);
    total++; if (cap_q.size() != 8) begin bad++; $display("FAIL walk_len got=%0d want=8", cap_q.size()); end
    for (int n = 0; n < 8 && n < cap_q.size(); n++) begin
      total++; if (cap_q[n] !== model_pair(1, n)) begin bad++; $display("FAIL walk_word%0d got=%h want=%h", n, cap_q[n], model_pair(1, n)); end
    end
    total++; if (cap_pass !== 1'b1) begin bad++; $display("FAIL walk_pass got=%b want=1", cap_pass); end
    total++; if (cap_cycles != 11) begin bad++; $display("FAIL walk_done_cycle got=%0d want=11", cap_cycles); end
  endtask

  task automatic test_inject();
    logic [15:0] exp3;
    int exp_err;
`ifdef PIPECLEANER_ERR_INJECT_EN
    exp_err = 1;
    exp3 = model_pair(0, 3) ^ 16'h0001;
`else
    exp_err = 0;
    exp3 = model_pair(0, 3);
`endif
    clear_force();
    run_burst(0, 8, 3, 0, 0, 0);
    total++; if (cap_err !== 16'(exp_err)) begin bad++; $display("FAIL inject_err got=%0d want=%0d", cap_err, exp_err); end
    total++; if (cap_pass !== (exp_err == 0)) begin bad++; $display("FAIL inject_pass got=%b want=%b", cap_pass, exp_err == 0); end
    total++; if (cap_q.size() > 3 && cap_q[3] !== exp3) begin bad++; $display("FAIL inject_word3 got=%h want=%h", cap_q[3], exp3); end
    total++; if (cap_q.size() > 4 && cap_q[4] !== model_pair(0, 4)) begin bad++; $display("FAIL inject_word4 got=%h want=%h", cap_q[4], model_pair(0, 4)); end
  endtask

  task automatic test_ena_freeze();
    int wrong;
    clear_force();
    run_burst(2, 10, 0, 0, 4, 3);
    wrong = 0;
    total++; if (cap_q.size() != 10) begin bad++; $display("FAIL freeze_len got=%0d want=10", cap_q.size()); end
    for (int n = 0; n < cap_q.size(); n++) if (cap_q[n] !== model_pair(2, n)) wrong++;
    total++; if (wrong != 0) begin bad++; $display("FAIL freeze_words got=%0d_wrong want=0_wrong", wrong); end
    total++; if (hold_bad != 0) begin bad++; $display("FAIL freeze_hold got=%0d_changes want=0_changes", hold_bad); end
    total++; if (cap_cycles != 16) begin bad++; $display("FAIL freeze_done_cycle got=%0d want=16", cap_cycles); end
    total++; if (cap_pass !== 1'b1) begin bad++; $display("FAIL freeze_pass got=%b want=1", cap_pass); end
  endtask

  task automatic test_start_ignored();
    clear_force();
    run_burst(3, 5, 0, 3, 0, 0);
    total++; if (cap_q.size() != 5) begin bad++; $display("FAIL restart_len got=%0d want=5", cap_q.size()); end
    total++; if (cap_cycles != 8) begin bad++; $display("FAIL restart_done_cycle got=%0d want=8", cap_cycles); end
    total++; if (cap_pass !== 1'b1) begin bad++; $display("FAIL restart_pass got=%b want=1", cap_pass); end
    // start in DRAIN must not restart either
    run_burst(0, 2, 0, 3, 0, 0);
    total++; if (cap_cycles != 5) begin bad++; $display("FAIL drain_start_done_cycle got=%0d want=5", cap_cycles); end
    // burst_len 0 behaves as 1
    run_burst(0, 0, 0, 0, 0, 0);
    total++; if (cap_q.size() != 1) begin bad++; $display("FAIL len0_len got=%0d want=1", cap_q.size()); end
    total++; if (cap_cycles != 4) begin bad++; $display("FAIL len0_done_cycle got=%0d want=4", cap_cycles); end
  endtask

  task automatic test_reset_mid();
    mode = 2'd2; burst_len = 8'd50; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    total++; if (tx_valid !== 1'b0) begin bad++; $display("FAIL rstmid_tx_valid got=%b want=0", tx_valid); end
    total++; if (tx_data !== 16'h0000) begin bad++; $display("FAIL rstmid_tx_data got=%h want=0000", tx_data); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rstmid_busy got=%b want=0", busy); end
    total++; if (err_count !== 16'd0) begin bad++; $display("FAIL rstmid_err got=%0d want=0", err_count); end
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    total++; if (done !== 1'b0) begin bad++; $display("FAIL rstmid_done got=%b want=0", done); end
    clear_force();
    run_burst(2, 12, 0, 0, 0, 0);
    total++; if (cap_pass !== 1'b1) begin bad++; $display("FAIL rstmid_rerun_pass got=%b want=1", cap_pass); end
    total++; if (cap_q.size() > 0 && cap_q[0] !== model_pair(2, 0)) begin bad++; $display("FAIL rstmid_rerun_word0 got=%h want=%h", cap_q[0], model_pair(2, 0)); end
  endtask

  task automatic test_random();
    int m, len, eff, exp_err, wrong;
    logic [7:0] w0;
    for (int it = 0; it < 8; it++) begin
      m = int'($urandom_range(0, 3));
      len = int'($urandom_range(0, 40));
      eff = (len == 0) ? 1 : len;
      clear_force();
      exp_err = 0;
      for (int n = 0; n < eff; n++) begin
        if ($urandom_range(0, 3) == 0) begin
          force_word[n] = 1'b1;
          w0 = model_word(m, 0, n);
          if (w0[3] == 1'b0) exp_err++;
        end
      end
      run_burst(m, len, 0, 0, 0, 0);
      clear_force();
      wrong = 0;
      for (int n = 0; n < cap_q.size(); n++) if (cap_q[n] !== model_pair(m, n)) wrong++;
      total++; if (cap_q.size() != eff) begin bad++; $display("FAIL rand%0d_len got=%0d want=%0d", it, cap_q.size(), eff); end
      total++; if (wrong != 0) begin bad++; $display("FAIL rand%0d_words got=%0d_wrong want=0_wrong", it, wrong); end
      total++; if (cap_err !== 16'(exp_err)) begin bad++; $display("FAIL rand%0d_err got=%0d want=%0d", it, cap_err, exp_err); end
      total++; if (cap_pass !== (exp_err == 0)) begin bad++; $display("FAIL rand%0d_pass got=%b want=%b", it, cap_pass, exp_err == 0); end
      total++; if (cap_cycles != eff + 3) begin bad++; $display("FAIL rand%0d_done_cycle got=%0d want=%0d", it, cap_cycles, eff + 3); end
    end
  endtask

  initial begin
    clear_force();
    test_reset();
    test_count();
    test_prbs();
    test_checker();
    test_abort_walk();
    test_inject();
    test_ena_freeze();
    test_start_ignored();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
